// File: rtl/aes_state_loader.sv
// Word-serial loader: assembles four 32-bit beats into a 128-bit AES state
// and holds it in a one-entry output register for the sub_byte datapath.
module aes_state_loader #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned STATE_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [0:WORD_W-1]   in_word,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [0:STATE_W-1]  out_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err_frame
);

  localparam int unsigned IDX_W = $clog2(STATE_W);

  localparam logic [1:0] FILL0 = 2'd0;
  localparam logic [1:0] FILL1 = 2'd1;
  localparam logic [1:0] FILL2 = 2'd2;
  localparam logic [1:0] FILL3 = 2'd3;

  logic [1:0]         r_beat_cnt;
  logic [0:STATE_W-1] r_asm;
  logic [0:STATE_W-1] r_out_state;
  logic               r_out_valid;
  logic               r_err_frame;

  logic [1:0]         w_beat_nxt;
  logic [0:STATE_W-1] w_asm_nxt;
  logic [0:STATE_W-1] w_state_nxt;
  logic               w_valid_nxt;
  logic               w_err_nxt;
  logic               w_accept;
  logic               w_consume;
  logic [IDX_W-1:0]   w_base;

  // Beat 3 is the only beat that can stall: it needs a free or draining output slot.
  assign in_ready  = !flush & ((r_beat_cnt != FILL3) | !r_out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_out_valid & out_ready;
  assign w_base    = IDX_W'(r_beat_cnt) * IDX_W'(WORD_W);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= FILL0;
      r_asm       <= '0;
      r_out_state <= '0;
      r_out_valid <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_beat_cnt  <= w_beat_nxt;
      r_asm       <= w_asm_nxt;
      r_out_state <= w_state_nxt;
      r_out_valid <= w_valid_nxt;
      r_err_frame <= w_err_nxt;
    end
  end

  // Next-state: beat sequencing, framing checks, output slot load/drain, flush.
  always_comb begin
    w_beat_nxt  = r_beat_cnt;
    w_asm_nxt   = r_asm;
    w_state_nxt = r_out_state;
    w_valid_nxt = r_out_valid;
    w_err_nxt   = 1'b0;
    if (flush) begin
      w_beat_nxt  = FILL0;
      w_valid_nxt = 1'b0;
    end else begin
      if (w_consume) begin
        w_valid_nxt = 1'b0;
      end
      if (w_accept) begin
        case (r_beat_cnt)
          FILL3: begin
            w_beat_nxt = FILL0;
            if (in_last) begin
              // Same-cycle drain and reload keeps out_valid high.
              w_state_nxt = {r_asm[0:STATE_W-WORD_W-1], in_word};
              w_valid_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          default: begin
            if (in_last) begin
              w_err_nxt  = 1'b1;
              w_beat_nxt = FILL0;
            end else begin
              w_asm_nxt[w_base +: WORD_W] = in_word;
              case (r_beat_cnt)
                FILL0:   w_beat_nxt = FILL1;
                FILL1:   w_beat_nxt = FILL2;
                default: w_beat_nxt = FILL3;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign out_state = r_out_state;
  assign out_valid = r_out_valid;
  assign err_frame = r_err_frame;

endmodule

// File: tb/tb_aes_state_loader.sv
// Directed and randomized-backpressure bench for aes_state_loader.
module tb_aes_state_loader;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] out_state;
  logic         out_valid;
  logic         out_ready;
  logic         err_frame;

  int n_checks;
  int n_errors;

  aes_state_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_frame (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat until accepted (bounded); returns 1 if accepted.
  task automatic send_beat(input logic [31:0] w, input logic last, output logic ok);
    ok       = 1'b0;
    in_word  = w;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_word  = 32'h0;
  endtask

  task automatic send_frame(input logic [127:0] f);
    logic ok;
    for (int k = 0; k < 4; k++) begin
      send_beat(f[127-32*k -: 32], k == 3, ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL send_frame beat %0d accepted=%0b required=1", k, ok);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_word = 32'h0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_state !== 128'h0 || err_frame !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset got v=%b s=%h e=%b r=%b required 0/0/0/1",
               out_valid, out_state, err_frame, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [127:0] exp;
    exp = 128'h00112233445566778899aabbccddeeff;
    out_ready = 1'b1;
    send_frame(exp);
    n_checks++;
    if (out_valid !== 1'b1 || out_state !== exp) begin
      n_errors++;
      $display("FAIL basic got v=%b s=%h required 1 %h", out_valid, out_state, exp);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_drain got v=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] fa, fb;
    logic ok, rdy_seen;
    fa = 128'h0123456789abcdeffedcba9876543210;
    fb = 128'hdeadbeefcafef00d1122334455667788;
    out_ready = 1'b0;
    send_frame(fa);
    for (int k = 0; k < 3; k++) begin
      send_beat(fb[127-32*k -: 32], 1'b0, ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL b2b beat %0d accepted=0 required=1", k);
      end
    end
    in_word = fb[31:0]; in_last = 1'b1; in_valid = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready) rdy_seen = 1'b1;
      tick();
    end
    n_checks++;
    if (rdy_seen !== 1'b0 || out_valid !== 1'b1 || out_state !== fa) begin
      n_errors++;
      $display("FAIL b2b_stall got rdy=%b v=%b s=%h required 0 1 %h",
               rdy_seen, out_valid, out_state, fa);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_release got in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_state !== fb) begin
      n_errors++;
      $display("FAIL b2b_swap got v=%b s=%h required 1 %h", out_valid, out_state, fb);
    end
    tick();
  endtask

  task automatic test_framing();
    logic ok;
    logic [127:0] fc;
    out_ready = 1'b1;
    send_beat(32'h11111111, 1'b0, ok);
    send_beat(32'h22222222, 1'b1, ok);
    n_checks++;
    if (err_frame !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL short_err got e=%b v=%b required 1 0", err_frame, out_valid);
    end
    tick();
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL short_pulse got e=%b required 0", err_frame);
    end
    fc = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
    out_ready = 1'b0;
    send_frame(fc);
    n_checks++;
    if (out_valid !== 1'b1 || out_state !== fc) begin
      n_errors++;
      $display("FAIL short_recover got v=%b s=%h required 1 %h", out_valid, out_state, fc);
    end
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) send_beat(32'h5a5a0000 + 32'(k), 1'b0, ok);
    n_checks++;
    if (err_frame !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL long_err got e=%b v=%b required 1 0", err_frame, out_valid);
    end
    fc = 128'h0f0e0d0c0b0a09080706050403020100;
    send_frame(fc);
    n_checks++;
    if (err_frame !== 1'b0 || out_valid !== 1'b1 || out_state !== fc) begin
      n_errors++;
      $display("FAIL long_recover got e=%b v=%b s=%h required 0 1 %h",
               err_frame, out_valid, out_state, fc);
    end
    tick();
  endtask

  task automatic test_flush();
    logic ok;
    logic [127:0] fe, ff;
    out_ready = 1'b1;
    send_beat(32'hffffffff, 1'b0, ok);
    send_beat(32'heeeeeeee, 1'b0, ok);
    flush = 1'b1; in_valid = 1'b1; in_word = 32'h99999999;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ready got in_ready=%b required 0", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    fe = 128'h13579bdf2468ace0fedcba9801234567;
    out_ready = 1'b0;
    send_frame(fe);
    n_checks++;
    if (out_valid !== 1'b1 || out_state !== fe) begin
      n_errors++;
      $display("FAIL flush_partial got v=%b s=%h required 1 %h", out_valid, out_state, fe);
    end
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_out got v=%b required 0", out_valid);
    end
    ff = 128'h89abcdef012345670011223344556677;
    send_frame(ff);
    n_checks++;
    if (out_valid !== 1'b1 || out_state !== ff) begin
      n_errors++;
      $display("FAIL flush_next got v=%b s=%h required 1 %h", out_valid, out_state, ff);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic ok;
    logic [127:0] fr;
    out_ready = 1'b0;
    send_frame(128'hcccccccc_dddddddd_eeeeeeee_ffffffff);
    for (int k = 0; k < 3; k++) send_beat(32'h77777777, 1'b0, ok);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_state !== 128'h0 || err_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got v=%b s=%h e=%b required 0 0 0",
               out_valid, out_state, err_frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fr = 128'h000102030405060708090a0b0c0d0e0f;
    out_ready = 1'b1;
    send_frame(fr);
    n_checks++;
    if (out_valid !== 1'b1 || out_state !== fr || err_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset got v=%b s=%h e=%b required 1 %h 0",
               out_valid, out_state, err_frame, fr);
    end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] q[$];
    logic [127:0] cur, prev_state, got;
    logic [1:0]   b;
    logic         acc, cons, prev_stall;
    int           nf, nr;
    nf = 0; nr = 0; b = 2'd0; prev_stall = 1'b0; prev_state = '0;
    cur = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 0; cyc < 60000 && nr < 1000; cyc++) begin
      in_valid  = (nf < 1000) && ($urandom_range(3) != 0);
      in_word   = cur[127-32*b -: 32];
      in_last   = (b == 2'd3);
      out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      acc  = in_valid & in_ready;
      cons = out_valid & out_ready;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_state !== prev_state) begin
          n_errors++;
          $display("FAIL rand_stable got v=%b s=%h required 1 %h", out_valid, out_state, prev_state);
        end
      end
      if (cons) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL rand_spurious got s=%h required no frame", out_state);
        end else begin
          got = q.pop_front();
          if (out_state !== got) begin
            n_errors++;
            $display("FAIL rand_data frame %0d got %h required %h", nr, out_state, got);
          end
        end
        nr++;
      end
      prev_stall = out_valid & !out_ready;
      prev_state = out_state;
      if (acc) begin
        if (b == 2'd3) begin
          q.push_back(cur);
          nf++;
          cur = {$urandom, $urandom, $urandom, $urandom};
        end
        b = b + 2'd1;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (nr != 1000 || q.size() != 0) begin
      n_errors++;
      $display("FAIL rand_count got %0d frames (%0d queued) required 1000 (0)", nr, q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
